mips_seq_divider: RTL and testbench

//  Multi-cycle integer divider for the MIPS ALU datapath, counterpart to the single-cycle add/sub unit.

---
 rtl/mips_seq_divider_if.sv | 25 ++
 rtl/mips_seq_divider.sv | 176 +++++++++++++++++
 tb/tb_mips_seq_divider.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mips_seq_divider_if.sv
// Handshake and operand/result bundle between the control FSM and the sequential divider.
interface mips_seq_divider_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             sign_ctrl;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, sign_ctrl, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, sign_ctrl, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/mips_seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock,
// quotient -> LO, remainder -> HI, sign fix-up in a dedicated final cycle.
module mips_seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mips_seq_divider_if.slave      bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             accept_c;
    logic             zero_div_c;
    logic             busy_nx;
    logic             done_nx;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_w;
    logic [WIDTH-1:0] quo_w;
    logic [WIDTH-1:0] dvs_mag;
    logic             sign_q;
    logic             sign_r;
    logic             dbz_pend;
    logic             ovf_pend;

    logic [WIDTH:0]   rem_sh_c;
    logic             trial_ok_c;
    logic [WIDTH-1:0] rem_next_c;
    logic [WIDTH-1:0] q_fix_c;
    logic [WIDTH-1:0] r_fix_c;

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    // A start is only honoured when no division is in flight.
    assign accept_c   = bus.start && ((state == S_IDLE) || (state == S_DONE));
    assign zero_div_c = (bus.divisor == '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept_c) state_nx = zero_div_c ? S_FIX : S_CALC;
            end
            S_CALC: begin
                if (cnt == CNT_LAST) state_nx = S_FIX;
            end
            S_FIX: begin
                state_nx = S_DONE;
            end
            S_DONE: begin
                if (accept_c) state_nx = zero_div_c ? S_FIX : S_CALC;
                else          state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the upcoming state so the registers line up with it.
    always_comb begin
        busy_nx = 1'b0;
        done_nx = 1'b0;
        case (state_nx)
            S_CALC:  busy_nx = 1'b1;
            S_FIX:   busy_nx = 1'b1;
            S_DONE:  done_nx = 1'b1;
            default: begin
                busy_nx = 1'b0;
                done_nx = 1'b0;
            end
        endcase
    end

    // One restoring step: the shifted partial remainder needs WIDTH+1 bits for large divisors.
    always_comb begin
        rem_sh_c   = {rem_w, quo_w[WIDTH-1]};
        trial_ok_c = (rem_sh_c >= {1'b0, dvs_mag});
        rem_next_c = trial_ok_c ? (rem_sh_c[WIDTH-1:0] - dvs_mag) : rem_sh_c[WIDTH-1:0];
    end

    // Final sign correction; a zero divisor returns the raw dividend kept in quo_w.
    always_comb begin
        q_fix_c = quo_w;
        r_fix_c = rem_w;
        if (dbz_pend) begin
            q_fix_c = ALL_ONES;
            r_fix_c = quo_w;
        end else begin
            if (sign_q) q_fix_c = neg(quo_w);
            if (sign_r) r_fix_c = neg(rem_w);
        end
    end

    // Working registers for the iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            rem_w    <= '0;
            quo_w    <= '0;
            dvs_mag  <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            dbz_pend <= 1'b0;
            ovf_pend <= 1'b0;
        end else if (accept_c) begin
            cnt      <= '0;
            rem_w    <= '0;
            sign_q   <= bus.sign_ctrl & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            sign_r   <= bus.sign_ctrl & bus.dividend[WIDTH-1];
            dbz_pend <= zero_div_c;
            ovf_pend <= bus.sign_ctrl && (bus.dividend == MOST_NEG) && (bus.divisor == ALL_ONES);
            dvs_mag  <= (bus.sign_ctrl && bus.divisor[WIDTH-1]) ? neg(bus.divisor) : bus.divisor;
            if (zero_div_c)
                quo_w <= bus.dividend;
            else if (bus.sign_ctrl && bus.dividend[WIDTH-1])
                quo_w <= neg(bus.dividend);
            else
                quo_w <= bus.dividend;
        end else if (state == S_CALC) begin
            cnt   <= cnt + CNT_W'(1);
            rem_w <= rem_next_c;
            quo_w <= {quo_w[WIDTH-2:0], trial_ok_c};
        end
    end

    // Registered outputs; results only change in the fix-up cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
        end else begin
            bus.busy <= busy_nx;
            bus.done <= done_nx;
            if (accept_c) begin
                bus.div_by_zero <= 1'b0;
                bus.overflow    <= 1'b0;
            end else if (state == S_FIX) begin
                bus.quotient    <= q_fix_c;
                bus.remainder   <= r_fix_c;
                bus.div_by_zero <= dbz_pend;
                bus.overflow    <= ovf_pend;
            end
        end
    end

endmodule

// File: tb/tb_mips_seq_divider.sv
// Directed, table-driven bench for mips_seq_divider (WIDTH=32) plus handshake/reset sequences.
module tb_mips_seq_divider;

    localparam int unsigned WIDTH = 32;

    logic clk;
    logic rst_n;

    mips_seq_divider_if #(.WIDTH(WIDTH)) bus ();

    mips_seq_divider #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs [14];
    int   n_checks;
    int   n_errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Caller is #1 after a rising edge; returns #1 after the edge that sampled start.
    task automatic launch(input vec_t v);
        bus.start     = 1'b1;
        bus.sign_ctrl = v.sgn;
        bus.dividend  = v.a;
        bus.divisor   = v.b;
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.sign_ctrl = ~v.sgn;
        bus.dividend  = $urandom;
        bus.divisor   = $urandom;
    endtask

    // Walks cycles T+1.. until done; optionally pulses a junk start at cycle pulse_at.
    task automatic run_to_done(input vec_t v, input int pulse_at, input string name);
        int   k;
        logic busy_bad;
        k = 1;
        busy_bad = 1'b0;
        forever begin
            if (bus.done === 1'b1 || k > 100) break;
            if (bus.busy !== 1'b1) busy_bad = 1'b1;
            if (k == pulse_at) begin
                bus.start     = 1'b1;
                bus.sign_ctrl = 1'b0;
                bus.dividend  = 32'd1000;
                bus.divisor   = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            k++;
        end
        bus.start = 1'b0;
        check({name, "_latency"}, 32'(k), 32'(v.lat));
        check({name, "_busy_during"}, {31'd0, busy_bad}, 32'd0);
        check({name, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
        check({name, "_q"}, bus.quotient, v.q);
        check({name, "_r"}, bus.remainder, v.r);
        check({name, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, v.dbz});
        check({name, "_ovf"}, {31'd0, bus.overflow}, {31'd0, v.ovf});
    endtask

    // One cycle after done: pulse must have ended, results held.
    task automatic after_done(input vec_t v, input string name);
        @(posedge clk); #1;
        check({name, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
        check({name, "_q_hold"}, bus.quotient, v.q);
    endtask

    initial begin
        logic saw_done;
        n_checks = 0;
        n_errors = 0;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 34};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 34};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 1'b0, 34};
        vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 1'b1, 34};
        vecs[4]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 1'b0, 34};
        vecs[5]  = '{1'b0, 32'h00001234,   32'd0,        32'hFFFFFFFF, 32'h00001234, 1'b1, 1'b0, 2};
        vecs[6]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1'b0, 34};
        vecs[7]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 1'b0, 34};
        vecs[8]  = '{1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 1'b0, 34};
        vecs[9]  = '{1'b1, 32'd0,          32'd5,        32'd0,        32'd0,        1'b0, 1'b0, 34};
        vecs[10] = '{1'b1, 32'hFFFFFFFF,   32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 2};
        vecs[11] = '{1'b0, 32'd5,          32'd7,        32'd0,        32'd5,        1'b0, 1'b0, 34};
        vecs[12] = '{1'b0, 32'hFFFFFFFF,   32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b0, 34};
        vecs[13] = '{1'b1, 32'h80000000,   32'd2,        32'hC0000000, 32'd0,        1'b0, 1'b0, 34};

        bus.start     = 1'b0;
        bus.sign_ctrl = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_q", bus.quotient, 32'd0);
        check("rst_r", bus.remainder, 32'd0);
        check("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        check("rst_ovf", {31'd0, bus.overflow}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            launch(vecs[i]);
            run_to_done(vecs[i], 0, $sformatf("v%0d", i));
            after_done(vecs[i], $sformatf("v%0d", i));
        end

        // start during CALC is ignored; the first result must stand.
        launch(vecs[0]);
        run_to_done(vecs[0], 5, "ignore_start");
        // start in the DONE cycle is taken immediately.
        launch(vecs[8]);
        run_to_done(vecs[8], 0, "back_to_back");
        after_done(vecs[8], "back_to_back");

        // Asynchronous reset mid-divide at cycle T+10.
        launch(vecs[0]);
        repeat (9) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_q", bus.quotient, 32'd0);
        check("abort_r", bus.remainder, 32'd0);
        check("abort_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        check("abort_ovf", {31'd0, bus.overflow}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0) saw_done = 1'b1;
        end
        check("abort_no_done", {31'd0, saw_done}, 32'd0);
        launch(vecs[6]);
        run_to_done(vecs[6], 0, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
